// File: rtl/adder_pkg.sv
// Shared definitions for the arbitrated adder path.
//   W_ADD     : width of the shared ripple-carry datapath
//   clog2_req : index width for a requester count (never below 1 bit)
//   req_id_t  : requester index wide enough for the largest legal N_REQ (8)
package adder_pkg;

    localparam int W_ADD = 28;

    typedef logic [$clog2(8)-1:0] req_id_t;

    function automatic int clog2_req(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_28bits.sv
// 28-bit ripple-carry adder: {cout, sum} = a + b + cin.
//   a, b : operands
//   cin  : carry-in
//   sum  : W_ADD-bit sum
//   cout : carry-out of the top bit
module rca_28bits
    import adder_pkg::*;
(
    input  logic [W_ADD-1:0] a,
    input  logic [W_ADD-1:0] b,
    input  logic             cin,
    output logic [W_ADD-1:0] sum,
    output logic             cout
);

    logic [W_ADD:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit, carry rippling upward.
    for (genvar i = 0; i < W_ADD; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W_ADD];

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin pick.
//   valid : request vector
//   ptr   : highest-priority index (searched first, then upward with wrap)
//   en    : grant allowed this cycle
//   gnt   : one-hot grant (all zero when nothing is granted)
//   idx   : index of the granted requester (0 when nothing is granted)
//   any   : a grant was issued
module rr_grant
    import adder_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = clog2_req(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // Walk offsets 0..N_REQ-1 from ptr; the first valid one wins.
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (en && !any && valid[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

    assign gnt = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one 28-bit ripple-carry adder between N_REQ
// requesters, with a single-entry registered result stage.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester handshake (at most one ready high)
//   req_a, req_b        : packed operands, requester i at [i*W +: W]
//   req_cin             : per-requester carry-in
//   res_valid/res_ready : result handshake
//   res_sum, res_cout   : registered sum and carry-out
//   res_id              : requester that produced the result
//   ops_done            : consumed-result count, saturating
module adder_rr_arbiter
    import adder_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int W     = W_ADD,
    parameter  int CNT_W = 16,
    localparam int ID_W  = clog2_req(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_cin,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W-1:0]       res_sum,
    output logic               res_cout,
    output logic [ID_W-1:0]    res_id,
    output logic [CNT_W-1:0]   ops_done
);

    logic [ID_W-1:0]  ptr;
    logic             free;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             accept;

    logic [W-1:0]     a_arr [N_REQ];
    logic [W-1:0]     b_arr [N_REQ];
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             op_cin;
    logic [W-1:0]     add_sum;
    logic             add_cout;

    // Output slot can take a new result if empty or being drained now.
    // Reset gating keeps req_ready low for every cycle rst_n is low.
    assign free = (!res_valid || res_ready) && rst_n;

    rr_grant #(.N_REQ(N_REQ)) u_grant (
        .valid (req_valid),
        .ptr   (ptr),
        .en    (free),
        .gnt   (gnt),
        .idx   (gnt_idx),
        .any   (accept)
    );

    // gnt only ever has a bit set where req_valid is high.
    assign req_ready = gnt;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*W +: W];
        assign b_arr[i] = req_b[i*W +: W];
    end

    assign op_a   = a_arr[gnt_idx];
    assign op_b   = b_arr[gnt_idx];
    assign op_cin = req_cin[gnt_idx];

    rca_28bits u_rca (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= '0;
            ops_done  <= '0;
        end else begin
            if (accept) begin
                // New result overwrites any result drained on this edge.
                res_valid <= 1'b1;
                res_sum   <= add_sum;
                res_cout  <= add_cout;
                res_id    <= gnt_idx;
                ptr       <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end

            if (res_valid && res_ready && (ops_done != {CNT_W{1'b1}}))
                ops_done <= ops_done + 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;

    localparam int N     = 4;
    localparam int W     = 28;
    localparam int CNT_W = 16;
    localparam int IW    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_cin = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [W-1:0]     res_sum;
    logic             res_cout;
    logic [IW-1:0]    res_id;
    logic [CNT_W-1:0] ops_done;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.N_REQ(N), .W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .ops_done  (ops_done)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int         m_ptr   = 0;
    bit         m_valid = 0;
    logic [W:0] m_res   = '0;
    int         m_id    = 0;
    int         m_ops   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j[IW-1:0]]) return j;
        end
        return -1;
    endfunction

    // One clock: check req_ready against the model, clock, update model,
    // then check the registered outputs. Inputs are driven at posedge+1.
    task automatic cycle(output int g);
        logic [N-1:0] er;
        logic [W:0]   s;
        #1;
        g = -1;
        if (rst_n && (!m_valid || res_ready)) g = pick();
        er = '0;
        if (g >= 0) er[g[IW-1:0]] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_valid = 0; m_res = '0; m_id = 0; m_ops = 0;
        end else begin
            if (m_valid && res_ready && m_ops < 65535) m_ops++;
            if (g >= 0) begin
                s = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]} + (W+1)'(req_cin[g[IW-1:0]]);
                m_res   = s;
                m_id    = g;
                m_valid = 1;
                m_ptr   = (g + 1) % N;
            end else if (m_valid && res_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk("res_valid", 64'(res_valid), 64'(m_valid));
        chk("res_sum",   64'(res_sum),   64'(m_res[W-1:0]));
        chk("res_cout",  64'(res_cout),  64'(m_res[W]));
        chk("res_id",    64'(res_id),    64'(m_id));
        chk("ops_done",  64'(ops_done),  64'(m_ops));
    endtask

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       cin;
        logic [W-1:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int g;
        int id0;
        logic [W-1:0] sum0;
        int ops0;

        vecs[0] = '{0, 28'h0FFFFFF, 28'h0000001, 1'b0, 28'h1000000, 1'b0};
        vecs[1] = '{0, 28'hFFFFFFF, 28'h0000001, 1'b1, 28'h0000001, 1'b1};
        vecs[2] = '{2, 28'h0000000, 28'h0000000, 1'b0, 28'h0000000, 1'b0};
        vecs[3] = '{3, 28'hFFFFFFF, 28'hFFFFFFF, 1'b1, 28'hFFFFFFF, 1'b1};
        vecs[4] = '{1, 28'h5555555, 28'hAAAAAAA, 1'b0, 28'hFFFFFFF, 1'b0};
        vecs[5] = '{1, 28'h5555555, 28'hAAAAAAA, 1'b1, 28'h0000000, 1'b1};
        vecs[6] = '{2, 28'h1234567, 28'h0FEDCBA, 1'b0, 28'h2222221, 1'b0};

        // Reset with all requesters valid
        rst_n = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, W'(i * 32'h100 + 1), W'(i), i[0]);
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_valid", 64'(res_valid), 64'd0);
            chk("rst_sum",   64'(res_sum),   64'd0);
            chk("rst_ops",   64'(ops_done),  64'd0);
        end

        // Fairness: strict rotation from ptr=0
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(g);
            chk("fair_id", 64'(res_id), 64'(i % N));
        end
        req_valid = '0;
        cycle(g);
        chk("fair_ops", 64'(ops_done), 64'd8);

        // Table-driven single requests (granted regardless of ptr)
        for (int v = 0; v < 7; v++) begin
            req_valid = '0;
            req_valid[vecs[v].id] = 1'b1;
            set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].cin);
            cycle(g);
            chk("tbl_valid", 64'(res_valid), 64'd1);
            chk("tbl_sum",   64'(res_sum),   64'(vecs[v].sum));
            chk("tbl_cout",  64'(res_cout),  64'(vecs[v].cout));
            chk("tbl_id",    64'(res_id),    64'(vecs[v].id));
        end
        req_valid = '0;
        cycle(g);

        // Backpressure
        req_valid = '1;
        res_ready = 1'b0;
        cycle(g);
        id0  = int'(res_id);
        sum0 = res_sum;
        ops0 = int'(ops_done);
        for (int i = 0; i < 5; i++) begin
            cycle(g);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_id",    64'(res_id),    64'(id0));
            chk("bp_sum",   64'(res_sum),   64'(sum0));
        end
        res_ready = 1'b1;
        cycle(g);
        chk("bp_next_id", 64'(res_id),   64'((id0 + 1) % N));
        chk("bp_ops1",    64'(ops_done), 64'(ops0 + 1));
        req_valid = '0;
        cycle(g);
        chk("bp_ops2",    64'(ops_done), 64'(ops0 + 2));

        // Sparse requests, then reset with a pending result
        rst_n = 1'b0;
        cycle(g);
        rst_n = 1'b1;
        req_valid = 4'b0010;
        cycle(g);
        chk("sp_first", 64'(res_id), 64'd1);
        req_valid = 4'b1010;
        cycle(g);
        chk("sp_id3", 64'(res_id), 64'd3);
        req_valid = 4'b0010;
        cycle(g);
        chk("sp_id1", 64'(res_id), 64'd1);
        rst_n = 1'b0;
        req_valid = '1;
        cycle(g);
        chk("sp_rst_valid", 64'(res_valid), 64'd0);
        rst_n = 1'b1;
        cycle(g);
        chk("sp_rst_ptr", 64'(res_id), 64'd0);
        req_valid = '0;
        cycle(g);

        // Randomized traffic: requesters hold valid+operands until granted
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 2 == 0)) begin
                    req_valid[i] = 1'b1;
                    set_req(i,
                            ($urandom % 8 == 0) ? {W{1'b1}} : W'($urandom),
                            ($urandom % 8 == 0) ? {W{1'b1}} : W'($urandom),
                            1'($urandom));
                end
            end
            res_ready = ($urandom % 4 != 0);
            rst_n = ($urandom % 150 != 0);
            cycle(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
